// File: rtl/lrsc_pkg.sv
// Shared types for the LR/SC-capable AXI-lite core initiator:
// request opcodes, AXI response codes and the transaction FSM states.
package lrsc_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_LR    = 2'b10,
        OP_SC    = 2'b11
    } lrsc_op_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AWW,
        ST_B,
        ST_RSP
    } lrsc_state_t;

endpackage

// File: rtl/lrsc_reservation.sv
// Single LR reservation: valid bit plus reserved word address.
// A set (successful LR) overrides a clear issued in the same cycle.
module lrsc_reservation #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:2] set_addr,
    input  logic [ADDR_WIDTH-1:2] chk_addr,
    output logic                  valid,
    output logic                  match
);

    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:2] addr_q, addr_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (clr) begin
            valid_d = 1'b0;
        end
        if (set) begin
            valid_d = 1'b1;
            addr_d  = set_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign valid = valid_q;
    assign match = valid_q && (addr_q == chk_addr);

endmodule

// File: rtl/axi_lrsc_master.sv
// Core-side AXI4-lite initiator: one outstanding LOAD/STORE/LR/SC at a time,
// with a local LR reservation that lets doomed SCs fail without touching the bus.
module axi_lrsc_master
    import lrsc_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 10,
    parameter int NUM_CORES       = 2,
    parameter int MASTER_ID_WIDTH = $clog2(NUM_CORES),
    parameter int CORE_ID         = 0
) (
    input  logic                       axi_aclk,
    input  logic                       axi_aresetn,

    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_op,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    input  logic [DATA_WIDTH-1:0]      req_wdata,
    input  logic [DATA_WIDTH/8-1:0]    req_wstrb,

    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic                       rsp_sc_fail,
    output logic                       rsp_err,

    output logic [ADDR_WIDTH-1:0]      axi_awaddr,
    output logic [2:0]                 axi_awprot,
    output logic                       axi_awvalid,
    output logic [MASTER_ID_WIDTH-1:0] axi_awid,
    output logic                       axi_awlock,
    input  logic                       axi_awready,

    output logic [DATA_WIDTH-1:0]      axi_wdata,
    output logic [DATA_WIDTH/8-1:0]    axi_wstrb,
    output logic                       axi_wvalid,
    input  logic                       axi_wready,

    input  logic [1:0]                 axi_bresp,
    input  logic                       axi_bvalid,
    input  logic [MASTER_ID_WIDTH-1:0] axi_bid,
    output logic                       axi_bready,

    output logic [ADDR_WIDTH-1:0]      axi_araddr,
    output logic [2:0]                 axi_arprot,
    output logic                       axi_arvalid,
    output logic [MASTER_ID_WIDTH-1:0] axi_arid,
    output logic                       axi_arlock,
    input  logic                       axi_arready,

    input  logic [DATA_WIDTH-1:0]      axi_rdata,
    input  logic [1:0]                 axi_rresp,
    input  logic                       axi_rvalid,
    input  logic [MASTER_ID_WIDTH-1:0] axi_rid,
    output logic                       axi_rready,

    input  logic [NUM_CORES-1:0]       axi_core_block
);

    localparam int                   STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [MASTER_ID_WIDTH-1:0] MY_ID = MASTER_ID_WIDTH'(CORE_ID);

    lrsc_state_t             state_q, state_d;
    lrsc_op_t                op_q, op_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    sc_fail_q, sc_fail_d;
    logic                    err_q, err_d;

    lrsc_op_t                req_op_e;
    logic                    accept;
    logic                    res_set, res_clr, res_valid, res_match;
    logic                    unused_block;

    assign req_op_e     = lrsc_op_t'(req_op);
    assign accept       = req_valid && req_ready;
    assign unused_block = ^axi_core_block;

    // The reservation is compared against the incoming request address so the
    // SC pass/fail decision can be made in the accept cycle.
    lrsc_reservation #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_reservation (
        .clk      (axi_aclk),
        .rst_n    (axi_aresetn),
        .set      (res_set),
        .clr      (res_clr),
        .set_addr (addr_q[ADDR_WIDTH-1:2]),
        .chk_addr (req_addr[ADDR_WIDTH-1:2]),
        .valid    (res_valid),
        .match    (res_match)
    );

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_LOAD;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            sc_fail_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            sc_fail_q <= sc_fail_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        sc_fail_d = sc_fail_q;
        err_d     = err_q;
        res_set   = 1'b0;
        res_clr   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d      = req_op_e;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = (req_op_e == OP_SC) ? '1 : req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    rdata_d   = '0;
                    sc_fail_d = 1'b0;
                    err_d     = 1'b0;
                    if ((req_op_e == OP_LR || req_op_e == OP_SC) && req_addr[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = ST_RSP;
                    end else begin
                        case (req_op_e)
                            OP_LOAD, OP_LR: state_d = ST_AR;
                            OP_STORE: begin
                                // Stores kill the reservation on a word match, even partial-byte ones.
                                res_clr = res_match;
                                state_d = ST_AWW;
                            end
                            default: begin
                                res_clr = 1'b1;
                                if (res_valid && res_match) begin
                                    state_d = ST_AWW;
                                end else begin
                                    sc_fail_d = 1'b1;
                                    state_d   = ST_RSP;
                                end
                            end
                        endcase
                    end
                end
            end
            ST_AR: begin
                if (axi_arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (axi_rvalid) begin
                    rdata_d = axi_rdata;
                    err_d   = (axi_rresp != RESP_OKAY) || (axi_rid != MY_ID);
                    res_set = (op_q == OP_LR) && (axi_rresp == RESP_OKAY) && (axi_rid == MY_ID);
                    state_d = ST_RSP;
                end
            end
            ST_AWW: begin
                aw_done_d = aw_done_q || axi_awready;
                w_done_d  = w_done_q || axi_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_B;
                end
            end
            ST_B: begin
                if (axi_bvalid) begin
                    if (op_q == OP_SC) begin
                        sc_fail_d = (axi_bresp != RESP_OKAY);
                        err_d     = (axi_bid != MY_ID);
                    end else begin
                        err_d = (axi_bresp != RESP_OKAY) || (axi_bid != MY_ID);
                    end
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request acceptance is also masked by reset so every ready output reads 0 while reset is held.
    always_comb begin
        req_ready   = axi_aresetn && (state_q == ST_IDLE) && !axi_core_block[CORE_ID];
        rsp_valid   = (state_q == ST_RSP);
        axi_arvalid = (state_q == ST_AR);
        axi_arlock  = (state_q == ST_AR) && (op_q == OP_LR);
        axi_rready  = (state_q == ST_R);
        axi_awvalid = (state_q == ST_AWW) && !aw_done_q;
        axi_wvalid  = (state_q == ST_AWW) && !w_done_q;
        axi_awlock  = (state_q == ST_AWW) && (op_q == OP_SC);
        axi_bready  = (state_q == ST_B);
    end

    assign axi_awaddr  = addr_q;
    assign axi_araddr  = addr_q;
    assign axi_awprot  = 3'b000;
    assign axi_arprot  = 3'b000;
    assign axi_awid    = MY_ID;
    assign axi_arid    = MY_ID;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = wstrb_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_sc_fail = sc_fail_q;
    assign rsp_err     = err_q;

endmodule
